// File: rtl/observer_pkg.sv
// observer_pkg: shared types and constants for the observer packet framer.
//   state_t        - packet FSM state (TS0/TS1 only reached with OBSERVER_TIMESTAMP_EN)
//   OVF_BIT        - header bit carrying the overflow snapshot
//   PKT_LEN_BASE   - packet length without timestamp (header + 4 data bytes)
//   PKT_LEN_TS     - packet length with timestamp (adds 2 bytes)
//   TS_W / DATA_W  - timestamp and sample widths
package observer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_D0   = 3'd2,
    ST_D1   = 3'd3,
    ST_D2   = 3'd4,
    ST_D3   = 3'd5,
    ST_TS0  = 3'd6,
    ST_TS1  = 3'd7
  } state_t;

  localparam int OVF_BIT      = 7;
  localparam int PKT_LEN_BASE = 5;
  localparam int PKT_LEN_TS   = 7;
  localparam int TS_W         = 16;
  localparam int DATA_W       = 32;

  // Header byte: overflow snapshot in OVF_BIT, source ID below it.
  function automatic logic [7:0] hdr_byte(input logic ovf, input logic [6:0] id);
    logic [7:0] b;
    b          = {1'b0, id};
    b[OVF_BIT] = ovf;
    return b;
  endfunction

endpackage

// File: rtl/observer_sync_fifo.sv
// observer_sync_fifo: single-clock FIFO with first-word-fall-through read.
//   clk, rst_n       - clock, asynchronous active-low reset (empties the FIFO)
//   wr_en, wr_data   - write request; ignored while full
//   rd_en            - pop request; ignored while empty
//   rd_data          - head entry, valid whenever empty=0
//   full, empty      - occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module observer_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok, rd_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/observer_packet_framer.sv
// observer_packet_framer: captures 32-bit samples into a FIFO and emits each
// as a byte packet on an AXI-stream byte interface.
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_valid, i_data         - sample strobe and value
//   o_tdata/o_tlast/o_tvalid, i_tready - packet byte stream
//   o_drop_cnt              - saturating count of samples dropped on full FIFO
// Packet: {ovf, ID}, then sample bytes LSB first. With OBSERVER_TIMESTAMP_EN
// defined, a 16-bit free-running timestamp is captured with each sample and
// appended low byte first (7-byte packet); otherwise the packet is 5 bytes.
module observer_packet_framer
  import observer_pkg::*;
#(
  parameter logic [6:0] ID    = 7'h00,
  parameter int         DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  output logic [7:0]  o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        i_tready,
  output logic [7:0]  o_drop_cnt
);

`ifdef OBSERVER_TIMESTAMP_EN
  localparam int     ENTRY_W = DATA_W + TS_W;
  localparam state_t LAST_ST = ST_TS1;
`else
  localparam int     ENTRY_W = DATA_W;
  localparam state_t LAST_ST = ST_D3;
`endif

  state_t              state, state_nxt;
  logic                fifo_full, fifo_empty;
  logic                push, drop, pop, accept;
  logic [ENTRY_W-1:0]  fifo_wdata, fifo_rdata;
  logic [DATA_W-1:0]   pkt_data;
  logic                pkt_ovf;
  logic                ovf;

  assign o_tvalid = (state != ST_IDLE);
  assign o_tlast  = (state == LAST_ST);
  assign accept   = o_tvalid & i_tready;
  // Fullness is sampled at the start of the cycle: a same-cycle pop does not
  // make room for the incoming sample.
  assign push     = i_valid & ~fifo_full;
  assign drop     = i_valid & fifo_full;
  // Load the packet register when idle, or back-to-back as the last byte goes.
  assign pop      = ~fifo_empty & ((state == ST_IDLE) | ((state == LAST_ST) & accept));

`ifdef OBSERVER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt, pkt_ts;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 1'b1;
  end

  assign fifo_wdata = {ts_cnt, i_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  pkt_ts <= '0;
    else if (pop)  pkt_ts <= fifo_rdata[ENTRY_W-1:DATA_W];
  end
`else
  assign fifo_wdata = i_data;
`endif

  observer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (push),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE) begin
      if (pop) state_nxt = ST_HDR;
    end else if (accept) begin
      if (state == LAST_ST) begin
        state_nxt = pop ? ST_HDR : ST_IDLE;
      end else begin
        case (state)
          ST_HDR:  state_nxt = ST_D0;
          ST_D0:   state_nxt = ST_D1;
          ST_D1:   state_nxt = ST_D2;
          ST_D2:   state_nxt = ST_D3;
          ST_D3:   state_nxt = ST_TS0;
          ST_TS0:  state_nxt = ST_TS1;
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      pkt_data   <= '0;
      pkt_ovf    <= 1'b0;
      ovf        <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        pkt_data <= fifo_rdata[DATA_W-1:0];
        pkt_ovf  <= ovf;
      end
      // A drop in the load cycle wins so the loss is reported next packet.
      if (drop)     ovf <= 1'b1;
      else if (pop) ovf <= 1'b0;
      if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

  // Output byte is a pure function of registered state, so it holds while stalled.
  always_comb begin
    o_tdata = 8'h00;
    case (state)
      ST_HDR:  o_tdata = hdr_byte(pkt_ovf, ID);
      ST_D0:   o_tdata = pkt_data[7:0];
      ST_D1:   o_tdata = pkt_data[15:8];
      ST_D2:   o_tdata = pkt_data[23:16];
      ST_D3:   o_tdata = pkt_data[31:24];
`ifdef OBSERVER_TIMESTAMP_EN
      ST_TS0:  o_tdata = pkt_ts[7:0];
      ST_TS1:  o_tdata = pkt_ts[15:8];
`endif
      default: o_tdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_observer_packet_framer.sv
// Self-checking bench for observer_packet_framer: directed scenarios plus
// random traffic, checked every cycle against a transaction-level model
// (sample queue + expected-byte queue).
module tb_observer_packet_framer;

  localparam logic [6:0] ID    = 7'h12;
  localparam int         DEPTH = 4;
`ifdef OBSERVER_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_tready = 1'b0;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic [7:0]  o_drop_cnt;

  observer_packet_framer #(.ID(ID), .DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .i_tready   (i_tready),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: buffered samples {ts, data}, pending packet bytes {last, byte}.
  logic [47:0] fifo_q[$];
  logic [8:0]  pkt_q[$];
  bit          ovf_m;
  int          drop_m;
  logic [15:0] ts_m;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    fifo_q.delete();
    pkt_q.delete();
    ovf_m  = 1'b0;
    drop_m = 0;
    ts_m   = '0;
  endtask

  // Called just after a falling edge: apply inputs, check this cycle's
  // outputs, advance the model across the coming rising edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic rdy);
    bit          exp_v, acc, full0, ne0, load;
    logic [47:0] e;
    logic [31:0] s;
    logic [15:0] t;
    i_valid  = v;
    i_data   = d;
    i_tready = rdy;
    #1;
    exp_v = (pkt_q.size() != 0);
    chk("tvalid", {31'b0, o_tvalid}, {31'b0, exp_v});
    if (exp_v) begin
      chk("tdata", {24'b0, o_tdata}, {24'b0, pkt_q[0][7:0]});
      chk("tlast", {31'b0, o_tlast}, {31'b0, pkt_q[0][8]});
    end
    chk("drop_cnt", {24'b0, o_drop_cnt}, drop_m);

    acc   = exp_v && rdy;
    full0 = (fifo_q.size() == DEPTH);
    ne0   = (fifo_q.size() != 0);
    if (acc) void'(pkt_q.pop_front());
    load = ne0 && (pkt_q.size() == 0);
    if (load) begin
      e = fifo_q.pop_front();
      s = e[31:0];
      t = e[47:32];
      pkt_q.push_back({1'b0, ovf_m, ID});
      for (int k = 0; k < 4; k++) pkt_q.push_back({(!TS_EN && k == 3), s[8*k +: 8]});
      if (TS_EN) begin
        pkt_q.push_back({1'b0, t[7:0]});
        pkt_q.push_back({1'b1, t[15:8]});
      end
    end
    if (v && full0) begin
      if (drop_m < 255) drop_m++;
      ovf_m = 1'b1;
    end else if (load) begin
      ovf_m = 1'b0;
    end
    if (v && !full0) fifo_q.push_back({ts_m, d});
    ts_m = ts_m + 16'd1;
    @(negedge i_clk);
  endtask

  // Asserts reset wherever the bench currently is; output must drop at once.
  task automatic do_reset();
    i_valid  = 1'b0;
    i_tready = 1'b0;
    i_rst_n  = 1'b0;
    #1;
    chk("rst_tvalid", {31'b0, o_tvalid}, 32'd0);
    model_clear();
    repeat (2) @(negedge i_clk);
    chk("rst_tdata", {24'b0, o_tdata}, 32'd0);
    chk("rst_tlast", {31'b0, o_tlast}, 32'd0);
    chk("rst_drop", {24'b0, o_drop_cnt}, 32'd0);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // Single sample, ready held high.
    cycle(1'b1, 32'hA1B2C3D4, 1'b1);
    repeat (10) cycle(1'b0, $urandom, 1'b1);

    // Backpressure pattern 1,0,0,1,...
    cycle(1'b1, 32'hA1B2C3D4, 1'b1);
    for (int i = 1; i < 24; i++) cycle(1'b0, $urandom, ((i % 4) == 0) || ((i % 4) == 3));

    // Overflow: 7 samples into a stalled stream.
    do_reset();
    repeat (7) cycle(1'b1, $urandom, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("ovf_drop_cnt", {24'b0, o_drop_cnt}, 32'd2);
    repeat (40) cycle(1'b0, $urandom, 1'b1);

    // Saturation of the drop counter.
    do_reset();
    repeat (300) cycle(1'b1, $urandom, 1'b0);
    chk("sat_drop_cnt", {24'b0, o_drop_cnt}, 32'd255);
    repeat (3) cycle(1'b1, $urandom, 1'b0);
    chk("sat_hold", {24'b0, o_drop_cnt}, 32'd255);
    repeat (40) cycle(1'b0, $urandom, 1'b1);

    // Reset after two bytes of a packet are accepted.
    do_reset();
    cycle(1'b1, 32'h5566_7788, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b1);
    do_reset();
    repeat (5) cycle(1'b0, $urandom, 1'b1);
    cycle(1'b1, 32'hCAFE_F00D, 1'b1);
    repeat (10) cycle(1'b0, $urandom, 1'b1);

    if (TS_EN) begin
      do_reset();
      while (ts_m != 16'h1234) cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b1, $urandom, 1'b1);
      repeat (10) cycle(1'b0, 32'h0, 1'b1);
      while (ts_m != 16'hFFFF) cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b1, $urandom, 1'b1);
      cycle(1'b1, $urandom, 1'b1);
      repeat (20) cycle(1'b0, 32'h0, 1'b1);
    end

    // Random traffic: light load, then heavy load with random stalls.
    do_reset();
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 1000; i++)
      cycle($urandom_range(0, 1) == 0, $urandom, $urandom_range(0, 2) != 0);
    repeat (60) cycle(1'b0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/observer_packet_framer.md
# observer_packet_framer

Upstream feeder for the emitter: captures 32-bit observation samples from a monitored point, buffers them in a small FIFO and frames each one as a byte packet on an AXI-stream byte interface (tdata/tlast/tvalid/tready). The packets are consumed directly by the emitter's stream input. Samples that arrive while the buffer is full are dropped and counted, and the next packet header flags the loss.

## Interface
- `ID`, 7'h00, 7-bit source identifier placed in every header byte.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `i_clk` in 1: the only clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_valid` in 1: sample strobe, one sample per cycle.
- `i_data` in 32: sample value.
- `o_tdata` out 8: packet byte.
- `o_tlast` out 1: last byte of packet.
- `o_tvalid` out 1: byte valid.
- `i_tready` in 1: downstream accepts the byte.
- `o_drop_cnt` out 8: saturating count of dropped samples.

## Operation
- **Push.** When `i_valid=1` and the FIFO is not full at the start of the cycle, the sample is written.
  - A full FIFO drops the sample, even if a pop occurs in the same cycle.
  - Each drop increments `o_drop_cnt`, which saturates at 255.
  - Each drop also sets the internal `ovf` flag.
- **Packet format.**
  - Byte 0 is the header `{ovf_snapshot, ID[6:0]}`.
  - Bytes 1–4 are `i_data`, least significant byte first.
  - `o_tlast` is asserted only on the final byte.
- **FSM states:** IDLE, HDR, D0, D1, D2, D3.
  - IDLE→HDR when the FIFO is not empty. This transition pops one entry into the packet register and snapshots `ovf` into the header.
  - `ovf` is cleared on that load unless a drop occurs in the same cycle, in which case it stays set.
  - Each state advances only on `o_tvalid & i_tready`.
  - After D3 is accepted, the FSM goes to HDR (with a pop and load) if the FIFO is non-empty, otherwise to IDLE.
- `o_tvalid` = (state ≠ IDLE).
- **AXI-stream rule:** while `o_tvalid=1 & i_tready=0`, `o_tdata` and `o_tlast` hold constant.
- **Reset values (all outputs and state):** `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0, `o_drop_cnt`=0, `ovf`=0, FIFO empty, state IDLE.
- **Reset mid-packet:** the packet is discarded. Nothing resumes after reset is released.

## Timing
- **Latency:** `i_valid` in cycle N → sample in the FIFO after edge N → loaded at edge N+1 → `o_tvalid`=1 with the header in cycle N+2.
- **Throughput:** one byte per cycle with `i_tready` held at 1. There is no bubble between back-to-back packets.
- **Sustained input:** the input may only average one sample per 5 cycles without drops. Bursts up to DEPTH+1 are absorbed, counting the packet register.
- **Reset:** assertion acts asynchronously, forcing `o_tvalid` low immediately. Deassertion is synchronous to `i_clk` and is the integrator's responsibility.

## Configuration
- **`OBSERVER_TIMESTAMP_EN` defined:**
  - A 16-bit free-running timestamp counter is compiled in. It resets to 0 and wraps from 0xFFFF to 0x0000.
  - The counter value is captured with each pushed sample, so the FIFO entry is 48 bits wide.
  - The packet gains states TS0 and TS1 after D3, carrying the timestamp low byte then high byte.
  - The packet is 7 bytes, and `o_tlast` moves to TS1.
- **Not defined:** no counter is built, the FIFO entry is 32 bits wide, the packet is 5 bytes, and `o_tlast` is on D3.

## Structure
- **Shared package `observer_pkg`:**
  - FSM state enum.
  - `OVF_BIT` = 7.
  - Packet lengths, 5 and 7.
  - Timestamp width, 16.
- **Sub-module `observer_sync_fifo`:**
  - Parameterised width and depth.
  - Pointers one bit wider than the address for full/empty detection.
  - Asynchronous active-low reset.
- The framer holds the FSM, packet register, `ovf` flag, drop counter and optional timestamp counter.

## Test plan
1. **Single sample.** `ID`=7'h12, sample 0xA1B2C3D4 pulsed in cycle N, `i_tready`=1 → bytes 0x12, 0xD4, 0xC3, 0xB2, 0xA1 in cycles N+2 to N+6, `o_tlast` on 0xA1 only, then `o_tvalid`=0.
2. **Backpressure.** Same stimulus with `i_tready` toggling 1,0,0,1,… → every byte held stable while stalled, exactly 5 accepted bytes, order preserved.
3. **Overflow.** `DEPTH`=4, `i_tready`=0, 7 consecutive samples → 5 kept, `o_drop_cnt`=2, first header 0x12. Release `i_tready` → second header 0x92, later headers 0x12.
4. **Saturation.** FIFO held full, 300 samples pushed → `o_drop_cnt`=255 and stays there.
5. **Reset mid-packet.** `i_rst_n` asserted after byte 2 is accepted → `o_tvalid`=0 in the same cycle. After release: no residual bytes, `o_drop_cnt`=0, and the next sample produces a clean packet.
6. **Timestamp build.** With `OBSERVER_TIMESTAMP_EN`, sample captured when the counter = 0x1234 → 7 bytes ending 0x34, 0x12 with `o_tlast` on 0x12. A sample at 0xFFFF followed by one a cycle later gives 0xFFFF then 0x0000.
